// File: rtl/water_reservoir_model.sv
// Plant model of the water reservoir: integrates valve inflow minus drain into a saturating
// level and drives a debounced thermometer sensor bus. Optional macro WATER_RESERVOIR_FAULT_EN adds sensor fault override ports.
module water_reservoir_model #(
  parameter int LEVEL_W    = 10,
  parameter int MAX_LEVEL  = 1000,
  parameter int T1         = 250,
  parameter int T2         = 500,
  parameter int T3         = 750,
  parameter int R1         = 1,
  parameter int R2         = 2,
  parameter int R3         = 4,
  parameter int RD         = 8,
  parameter int DEBOUNCE   = 3,
  parameter int INIT_LEVEL = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fr1,
  input  logic               fr2,
  input  logic               fr3,
  input  logic               dfr,
  input  logic               drain_en,
  input  logic [3:0]         drain_rate,
`ifdef WATER_RESERVOIR_FAULT_EN
  input  logic [3:1]         fault_mask,
  input  logic [3:1]         fault_val,
`endif
  output logic [3:1]         s,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               underflow
);

  localparam int SW = LEVEL_W + 2;
  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic signed [SW-1:0] MAX_S  = SW'(MAX_LEVEL);
  localparam logic [CW-1:0]        LAST_C = CW'(DEBOUNCE - 1);

  logic [LEVEL_W-1:0]       level_r;
  logic [LEVEL_W-1:0]       level_nxt_s;
  logic                     overflow_r;
  logic                     overflow_nxt_s;
  logic                     underflow_r;
  logic                     underflow_nxt_s;
  logic signed [SW-1:0]     inflow_s;
  logic signed [SW-1:0]     outflow_s;
  logic signed [SW-1:0]     sum_s;
  logic [3:1]               raw_s;
  logic [3:1]               s_r;
  logic [3:1]               s_nxt_s;
  logic [CW-1:0]            cnt_r   [3:1];
  logic [CW-1:0]            cnt_nxt_s [3:1];

  // Net flow and saturating level update
  always_comb begin
    inflow_s  = (fr1 ? SW'(R1) : {SW{1'b0}})
              + (fr2 ? SW'(R2) : {SW{1'b0}})
              + (fr3 ? SW'(R3) : {SW{1'b0}})
              + (dfr ? SW'(RD) : {SW{1'b0}});
    outflow_s = drain_en ? $signed({{(SW-4){1'b0}}, drain_rate}) : {SW{1'b0}};
    sum_s     = $signed({2'b00, level_r}) + inflow_s - outflow_s;
    level_nxt_s     = level_r;
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;
    if (sum_s > MAX_S) begin
      level_nxt_s    = LEVEL_W'(MAX_LEVEL);
      overflow_nxt_s = 1'b1;
    end else if (sum_s < $signed({SW{1'b0}})) begin
      level_nxt_s     = {LEVEL_W{1'b0}};
      underflow_nxt_s = 1'b1;
    end else begin
      level_nxt_s = sum_s[LEVEL_W-1:0];
    end
  end

  // Raw threshold comparison from the registered level
  always_comb begin
    raw_s[1] = (level_r >= LEVEL_W'(T1));
    raw_s[2] = (level_r >= LEVEL_W'(T2));
    raw_s[3] = (level_r >= LEVEL_W'(T3));
  end

  // Per-bit debounce: a single cycle of agreement restarts the count
  always_comb begin
    s_nxt_s = s_r;
    for (int k = 1; k <= 3; k++) begin
      cnt_nxt_s[k] = {CW{1'b0}};
      if (raw_s[k] == s_r[k]) begin
        cnt_nxt_s[k] = {CW{1'b0}};
      end else if (cnt_r[k] == LAST_C) begin
        s_nxt_s[k]   = raw_s[k];
        cnt_nxt_s[k] = {CW{1'b0}};
      end else begin
        cnt_nxt_s[k] = cnt_r[k] + CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r     <= LEVEL_W'(INIT_LEVEL);
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      s_r         <= 3'b000;
      for (int k = 1; k <= 3; k++) cnt_r[k] <= {CW{1'b0}};
    end else begin
      level_r     <= level_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
      s_r         <= s_nxt_s;
      for (int k = 1; k <= 3; k++) cnt_r[k] <= cnt_nxt_s[k];
    end
  end

  assign level     = level_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

`ifdef WATER_RESERVOIR_FAULT_EN
  // Fault override leaves the debounced state untouched so release is immediate
  assign s = (s_r & ~fault_mask) | (fault_val & fault_mask);
`else
  assign s = s_r;
`endif

endmodule

// File: tb/tb_water_reservoir_model.sv
// Directed self-checking bench for water_reservoir_model: reset, fill/sensor latency,
// saturation flags, debounce glitch rejection and (when enabled) fault override.
module tb_water_reservoir_model;

  logic       clk;
  logic       reset;
  logic       fr1, fr2, fr3, dfr, drain_en;
  logic [3:0] drain_rate;
  logic [3:1] s;
  logic [9:0] level;
  logic       overflow, underflow;
`ifdef WATER_RESERVOIR_FAULT_EN
  logic [3:1] fault_mask, fault_val;
`endif

  int n_vec = 0;
  int n_err = 0;

  water_reservoir_model dut (
    .clk(clk), .reset(reset), .fr1(fr1), .fr2(fr2), .fr3(fr3), .dfr(dfr),
    .drain_en(drain_en), .drain_rate(drain_rate),
`ifdef WATER_RESERVOIR_FAULT_EN
    .fault_mask(fault_mask), .fault_val(fault_val),
`endif
    .s(s), .level(level), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic b, input logic c, input logic d,
                        input logic de, input logic [3:0] dr);
    fr1 = a; fr2 = b; fr3 = c; dfr = d; drain_en = de; drain_rate = dr;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (level !== 10'd0 || s !== 3'b000 || overflow !== 1'b0 || underflow !== 1'b0) begin
        $display("FAIL reset edge%0d: level=%0d s=%b ovf=%b unf=%b, want 0 000 0 0",
                 i, level, s, overflow, underflow);
        n_err++;
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int e = 1; e <= 191; e++) begin
      tick();
      if (e == 1 || e == 63 || e == 125 || e == 188 || e == 191) begin
        n_vec++;
        if (level !== 10'(4 * e)) begin
          $display("FAIL fill_level edge%0d: got %0d want %0d", e, level, 4 * e);
          n_err++;
        end
      end
      if (e == 65 || e == 66 || e == 127 || e == 128 || e == 190 || e == 191) begin
        logic [3:1] exp_s;
        exp_s = (e < 66) ? 3'b000 : (e < 128) ? 3'b001 : (e < 191) ? 3'b011 : 3'b111;
        n_vec++;
        if (s !== exp_s) begin
          $display("FAIL fill_sensor edge%0d: got %b want %b", e, s, exp_s);
          n_err++;
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    #1;
    n_vec++;
    if (level !== 10'd0 || s !== 3'b000 || overflow !== 1'b0 || underflow !== 1'b0) begin
      $display("FAIL mid_reset: level=%0d s=%b ovf=%b unf=%b, want 0 000 0 0",
               level, s, overflow, underflow);
      n_err++;
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
  endtask

  task automatic test_glitch();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (62) tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    n_vec++;
    if (level !== 10'd249 || s !== 3'b000) begin
      $display("FAIL glitch_setup: level=%0d s=%b want 249 000", level, s);
      n_err++;
    end
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      else            set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
      tick();
      n_vec++;
      if (level !== ((i % 2 == 0) ? 10'd250 : 10'd249) || s !== 3'b000) begin
        $display("FAIL glitch_toggle%0d: level=%0d s=%b", i, level, s);
        n_err++;
      end
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_vec++;
      if (s !== ((e < 4) ? 3'b000 : 3'b001)) begin
        $display("FAIL glitch_hold edge%0d: got %b want %b", e, s, (e < 4) ? 3'b000 : 3'b001);
        n_err++;
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (248) tick();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    n_vec++;
    if (level !== 10'd994 || overflow !== 1'b0) begin
      $display("FAIL ovf_setup: level=%0d ovf=%b want 994 0", level, overflow);
      n_err++;
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    n_vec++;
    if (level !== 10'd1000 || overflow !== 1'b1 || underflow !== 1'b0) begin
      $display("FAIL ovf_sat: level=%0d ovf=%b unf=%b want 1000 1 0", level, overflow, underflow);
      n_err++;
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd15);
    tick();
    n_vec++;
    if (level !== 10'd1000 || overflow !== 1'b1) begin
      $display("FAIL ovf_net0: level=%0d ovf=%b want 1000 1", level, overflow);
      n_err++;
    end
  endtask

  task automatic test_underflow();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
    repeat (66) tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    tick();
    n_vec++;
    if (level !== 10'd5 || underflow !== 1'b0) begin
      $display("FAIL unf_setup: level=%0d unf=%b want 5 0", level, underflow);
      n_err++;
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    tick();
    n_vec++;
    if (level !== 10'd0 || underflow !== 1'b1 || overflow !== 1'b1) begin
      $display("FAIL unf_sat: level=%0d unf=%b ovf=%b want 0 1 1", level, underflow, overflow);
      n_err++;
    end
  endtask

`ifdef WATER_RESERVOIR_FAULT_EN
  task automatic test_fault();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    repeat (130) tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    fault_mask = 3'b100;
    fault_val  = 3'b100;
    #1;
    n_vec++;
    if (s !== 3'b111) begin
      $display("FAIL fault_force: got %b want 111", s);
      n_err++;
    end
    fault_mask = 3'b000;
    #1;
    n_vec++;
    if (s !== 3'b011) begin
      $display("FAIL fault_release: got %b want 011", s);
      n_err++;
    end
  endtask
`endif

  initial begin
`ifdef WATER_RESERVOIR_FAULT_EN
    fault_mask = 3'b000;
    fault_val  = 3'b000;
`endif
    test_reset();
    test_fill();
    test_mid_reset();
    test_glitch();
    test_overflow();
    test_underflow();
    test_mid_reset();
`ifdef WATER_RESERVOIR_FAULT_EN
    test_fault();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
